nlx_sram_arb: RTL and testbench

NLX_SRAM_ARB -- requirements
Module: nlx_sram_arb

---
 rtl/nlx_sram_pkg.sv | 28 ++
 rtl/nlx_rr_arb2.sv | 42 ++++
 rtl/nlx_sram_arb.sv | 108 ++++++++++
 tb/tb_nlx_sram_arb.sv | 272 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/nlx_sram_pkg.sv
// -----------------------------------------------------------------------------
// nlx_sram_pkg
// Shared definitions for the two-requester SRAM arbiter:
//   - default address / data / byte-enable widths
//   - req_t : one requester command {we, addr, wdata} at default widths
//   - tag_t : per-command tracking tag carried down the read-latency pipeline
// -----------------------------------------------------------------------------
package nlx_sram_pkg;

  localparam int ADDR_W_DEF = 16;
  localparam int DATA_W_DEF = 32;
  localparam int BE_W_DEF   = DATA_W_DEF / 8;

  // A command as issued by a requester; we == '0 marks a read.
  typedef struct packed {
    logic [BE_W_DEF-1:0]   we;
    logic [ADDR_W_DEF-1:0] addr;
    logic [DATA_W_DEF-1:0] wdata;
  } req_t;

  // Tracking tag: slot occupied, command was a read, originating requester.
  typedef struct packed {
    logic valid;
    logic is_read;
    logic id;
  } tag_t;

endpackage

// File: rtl/nlx_rr_arb2.sv
// -----------------------------------------------------------------------------
// nlx_rr_arb2
// Two-way round-robin arbiter. A lone request always wins; on contention the
// requester not granted most recently wins. The pointer moves only on a grant.
//   clk, rst  : clock, synchronous active-high reset (pointer favours req 0)
//   req[1:0]  : request vector
//   advance   : a grant was taken this cycle; update the pointer
//   gnt[1:0]  : one-hot grant, purely a function of req and the pointer
// -----------------------------------------------------------------------------
module nlx_rr_arb2 (
  input  logic       clk,
  input  logic       rst,
  input  logic [1:0] req,
  input  logic       advance,
  output logic [1:0] gnt
);

  // ptr == 0 favours requester 0, ptr == 1 favours requester 1.
  logic ptr;

  always_comb begin
    // NOTE: gnt is assigned a default before the case so every path drives
    // it and no latch is inferred.
    gnt = 2'b00;
    unique case (req)
      2'b01:   gnt = 2'b01;
      2'b10:   gnt = 2'b10;
      2'b11:   gnt = ptr ? 2'b10 : 2'b01;
      default: gnt = 2'b00;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ptr <= 1'b0;
    end else if (advance && (gnt != 2'b00)) begin
      // Favour whichever requester did not just win.
      ptr <= ~gnt[1];
    end
  end

endmodule

// File: rtl/nlx_sram_arb.sv
// -----------------------------------------------------------------------------
// nlx_sram_arb
// Arbitrates two requesters onto one single-port SRAM, one command per cycle
// with no bubbles. The accepted command is registered onto the SRAM pins for
// the following cycle. Reads are tracked through a tag shift register of depth
// 1+RD_LAT and return, in acceptance order, to the originating requester as a
// one-cycle rsp_valid pulse with registered data. Writes return nothing.
//   clk, rst         : clock, synchronous active-high reset
//   req_valid/ready  : per-requester command handshake (ready = grant)
//   req_we/addr/wdata: per-requester command; req_we == 0 is a read
//   rsp_valid/rdata  : per-requester read response (no back-pressure)
//   sram_we/addr/wdata, sram_rdata : SRAM interface
// Parameters: ADDR_W, DATA_W, RD_LAT (SRAM read latency, legal 1..4).
// -----------------------------------------------------------------------------
module nlx_sram_arb
  import nlx_sram_pkg::*;
#(
  parameter  int ADDR_W = ADDR_W_DEF,
  parameter  int DATA_W = DATA_W_DEF,
  parameter  int RD_LAT = 1,
  localparam int BE_W   = DATA_W / 8
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [1:0]             req_valid,
  output logic [1:0]             req_ready,
  input  logic [1:0][BE_W-1:0]   req_we,
  input  logic [1:0][ADDR_W-1:0] req_addr,
  input  logic [1:0][DATA_W-1:0] req_wdata,
  output logic [1:0]             rsp_valid,
  output logic [1:0][DATA_W-1:0] rsp_rdata,
  output logic [BE_W-1:0]        sram_we,
  output logic [ADDR_W-1:0]      sram_addr,
  output logic [DATA_W-1:0]      sram_wdata,
  input  logic [DATA_W-1:0]      sram_rdata
);

  logic [1:0]      gnt;
  logic            accept;
  logic            wid;
  tag_t [RD_LAT:0] pipe;
  tag_t            tail;

  // Requests are masked during reset so nothing is granted or accepted.
  nlx_rr_arb2 u_arb (
    .clk     (clk),
    .rst     (rst),
    .req     (req_valid & {2{~rst}}),
    .advance (accept),
    .gnt     (gnt)
  );

  // No back-pressure from the SRAM: a grant is an acceptance.
  assign req_ready = gnt;
  assign accept    = |gnt;
  assign wid       = gnt[1];

  // SRAM command register: drive the accepted command for exactly one cycle;
  // when idle, deassert we but keep addr/wdata stable.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples pre-edge values regardless of statement order.
    if (rst) begin
      sram_we    <= '0;
      sram_addr  <= '0;
      sram_wdata <= '0;
    end else if (accept) begin
      sram_we    <= req_we[wid];
      sram_addr  <= req_addr[wid];
      sram_wdata <= req_wdata[wid];
    end else begin
      sram_we    <= '0;
    end
  end

  // Tag pipeline: pipe[0] is loaded at the acceptance edge, so pipe[RD_LAT]
  // describes the command whose read data is on sram_rdata at the next edge.
  always_ff @(posedge clk) begin
    if (rst) begin
      pipe <= '0;
    end else begin
      pipe[0] <= '{valid:   accept,
                   is_read: accept && (req_we[wid] == '0),
                   id:      wid};
      for (int k = 1; k <= RD_LAT; k++) begin
        pipe[k] <= pipe[k-1];
      end
    end
  end

  assign tail = pipe[RD_LAT];

  // Response register: one-cycle valid pulse; data holds until the next
  // read response for that requester.
  always_ff @(posedge clk) begin
    if (rst) begin
      rsp_valid <= '0;
      rsp_rdata <= '0;
    end else begin
      rsp_valid <= '0;
      if (tail.valid && tail.is_read) begin
        rsp_valid[tail.id] <= 1'b1;
        rsp_rdata[tail.id] <= sram_rdata;
      end
    end
  end

endmodule

// File: tb/tb_nlx_sram_arb.sv
// -----------------------------------------------------------------------------
// tb_nlx_sram_arb
// Directed bench for nlx_sram_arb. Two instances (RD_LAT=1 and RD_LAT=3) share
// the same request stimulus, each with its own behavioural SRAM. Every cycle
// the bench compares grants, SRAM pins and responses against hand-computed
// expectations; expected read responses are queued with their acceptance
// cycle and must appear exactly 2+RD_LAT cycles later, in order.
// Unwritten SRAM words read as {16'hC0DE, 8'h00, addr[7:0]}.
// -----------------------------------------------------------------------------
module tb_nlx_sram_arb;
  import nlx_sram_pkg::*;

  typedef struct {
    int          id;
    logic [31:0] data;
    int          acc;
  } exp_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic             rst;
  logic [1:0]       req_valid;
  req_t             cur [2];
  logic [1:0][3:0]  req_we;
  logic [1:0][15:0] req_addr;
  logic [1:0][31:0] req_wdata;

  assign req_we    = {cur[1].we,    cur[0].we};
  assign req_addr  = {cur[1].addr,  cur[0].addr};
  assign req_wdata = {cur[1].wdata, cur[0].wdata};

  logic [1:0]       ready_1, ready_3, rv_1, rv_3;
  logic [1:0][31:0] rd_1, rd_3;
  logic [3:0]       swe_1, swe_3;
  logic [15:0]      sa_1, sa_3;
  logic [31:0]      swd_1, swd_3, srd_1, srd_3;

  nlx_sram_arb #(.RD_LAT(1)) u_dut_l1 (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(ready_1),
    .req_we(req_we), .req_addr(req_addr), .req_wdata(req_wdata),
    .rsp_valid(rv_1), .rsp_rdata(rd_1), .sram_we(swe_1), .sram_addr(sa_1),
    .sram_wdata(swd_1), .sram_rdata(srd_1)
  );

  nlx_sram_arb #(.RD_LAT(3)) u_dut_l3 (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(ready_3),
    .req_we(req_we), .req_addr(req_addr), .req_wdata(req_wdata),
    .rsp_valid(rv_3), .rsp_rdata(rd_3), .sram_we(swe_3), .sram_addr(sa_3),
    .sram_wdata(swd_3), .sram_rdata(srd_3)
  );

  // Behavioural SRAMs with byte writes and RD_LAT register stages.
  bit [31:0]   mem_1 [256];
  bit [31:0]   mem_3 [256];
  bit [255:0]  wr_1, wr_3;
  logic [31:0] p1, p3a, p3b, p3c;

  always @(posedge clk) begin
    for (int b = 0; b < 4; b++) begin
      if (swe_1[b]) mem_1[sa_1[7:0]][8*b +: 8] <= swd_1[8*b +: 8];
      if (swe_3[b]) mem_3[sa_3[7:0]][8*b +: 8] <= swd_3[8*b +: 8];
    end
    if (|swe_1) wr_1[sa_1[7:0]] <= 1'b1;
    if (|swe_3) wr_3[sa_3[7:0]] <= 1'b1;
    p1  <= wr_1[sa_1[7:0]] ? mem_1[sa_1[7:0]] : {16'hC0DE, 8'h00, sa_1[7:0]};
    p3a <= wr_3[sa_3[7:0]] ? mem_3[sa_3[7:0]] : {16'hC0DE, 8'h00, sa_3[7:0]};
    p3b <= p3a;
    p3c <= p3b;
  end

  assign srd_1 = p1;
  assign srd_3 = p3c;

  // Bookkeeping
  int          checks   = 0;
  int          failures = 0;
  int          cyc      = 0;
  exp_t        q [$];
  int          head [2];
  logic [31:0] last_rd [2][2];
  logic [3:0]  e_we;
  logic [15:0] e_addr;
  logic [31:0] e_wd;
  logic        ptr_m;

  localparam req_t NOP = '0;

  task automatic check(input string tag, input logic [63:0] got,
                       input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  function automatic req_t mk(input logic [3:0] be, input logic [15:0] a,
                              input logic [31:0] d);
    req_t r;
    r.we    = be;
    r.addr  = a;
    r.wdata = d;
    return r;
  endfunction

  function automatic logic [31:0] pat(input logic [15:0] a);
    return {16'hC0DE, 8'h00, a[7:0]};
  endfunction

  task automatic drive(input logic [1:0] v, input req_t r0, input req_t r1);
    req_valid = v;
    cur[0]    = r0;
    cur[1]    = r1;
  endtask

  // Compare one instance's outputs against the expected SRAM command and the
  // response (if any) due this cycle.
  task automatic mon(input int k, input int lat, input logic [1:0] rv,
                     input logic [1:0][31:0] rd, input logic [3:0] swe,
                     input logic [15:0] sa, input logic [31:0] swd);
    logic [1:0] exp_rv;
    exp_rv = 2'b00;
    if (head[k] < q.size() && (q[head[k]].acc + 2 + lat == cyc)) begin
      exp_rv[q[head[k]].id]         = 1'b1;
      last_rd[k][q[head[k]].id]     = q[head[k]].data;
      head[k]++;
    end
    check($sformatf("rsp_valid_l%0d", lat), rv, exp_rv);
    check($sformatf("rsp_rdata0_l%0d", lat), rd[0], last_rd[k][0]);
    check($sformatf("rsp_rdata1_l%0d", lat), rd[1], last_rd[k][1]);
    check($sformatf("sram_we_l%0d", lat), swe, e_we);
    check($sformatf("sram_addr_l%0d", lat), sa, e_addr);
    check($sformatf("sram_wdata_l%0d", lat), swd, e_wd);
  endtask

  // One clock cycle with the currently driven inputs. eg is the expected
  // grant; x0/x1 the read data expected if requester 0/1 is granted a read.
  task automatic step(input logic [1:0] eg, input logic [31:0] x0,
                      input logic [31:0] x1);
    int   w;
    exp_t e;
    @(negedge clk);
    cyc++;
    mon(0, 1, rv_1, rd_1, swe_1, sa_1, swd_1);
    mon(1, 3, rv_3, rd_3, swe_3, sa_3, swd_3);
    check("ready_l1", ready_1, eg);
    check("ready_l3", ready_3, eg);
    if (eg != 2'b00) begin
      w = eg[1] ? 1 : 0;
      if (cur[w].we == 4'h0) begin
        e.id   = w;
        e.data = (w == 1) ? x1 : x0;
        e.acc  = cyc;
        q.push_back(e);
      end
      e_we   = cur[w].we;
      e_addr = cur[w].addr;
      e_wd   = cur[w].wdata;
    end else begin
      e_we = 4'h0;
    end
    if (rst) begin
      e_we    = 4'h0;
      e_addr  = 16'h0;
      e_wd    = 32'h0;
      head[0] = q.size();
      head[1] = q.size();
      for (int k = 0; k < 2; k++) begin
        last_rd[k][0] = 32'h0;
        last_rd[k][1] = 32'h0;
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic drain();
    drive(2'b00, NOP, NOP);
    for (int n = 0; n < 8; n++) step(2'b00, 32'h0, 32'h0);
  endtask

  task automatic reset_cycle();
    rst = 1'b1;
    drive(2'b00, NOP, NOP);
    step(2'b00, 32'h0, 32'h0);
    rst = 1'b0;
  endtask

  initial begin
    logic [1:0]  v;
    logic [1:0]  eg;
    logic [15:0] a0, a1;

    head[0] = 0;
    head[1] = 0;
    for (int k = 0; k < 2; k++) begin
      last_rd[k][0] = 32'h0;
      last_rd[k][1] = 32'h0;
    end
    e_we   = 4'h0;
    e_addr = 16'h0;
    e_wd   = 32'h0;

    rst = 1'b1;
    drive(2'b00, NOP, NOP);
    @(posedge clk);
    #1;
    step(2'b00, 32'h0, 32'h0);
    step(2'b00, 32'h0, 32'h0);
    rst = 1'b0;

    // Single write right after reset, then a read of it by requester 1.
    drive(2'b01, mk(4'hF, 16'h0010, 32'hA5A5_0001), NOP);
    step(2'b01, 32'h0, 32'h0);
    drive(2'b10, NOP, mk(4'h0, 16'h0010, 32'h0));
    step(2'b10, 32'h0, 32'hA5A5_0001);
    drain();

    // Byte-enable merge.
    drive(2'b01, mk(4'hF, 16'h0020, 32'h1122_3344), NOP);
    step(2'b01, 32'h0, 32'h0);
    drive(2'b01, mk(4'b0100, 16'h0020, 32'h00AA_0000), NOP);
    step(2'b01, 32'h0, 32'h0);
    drive(2'b01, mk(4'h0, 16'h0020, 32'h0), NOP);
    step(2'b01, 32'h11AA_3344, 32'h0);
    drain();

    // Contention from reset: alternate grants, no idle SRAM cycle.
    reset_cycle();
    for (int n = 0; n < 6; n++) begin
      drive(2'b11, mk(4'hF, 16'h0030, 32'h3000_0000 + 32'(n)),
                   mk(4'hF, 16'h0031, 32'h3100_0000 + 32'(n)));
      step((n % 2 == 1) ? 2'b10 : 2'b01, 32'h0, 32'h0);
    end
    drive(2'b11, mk(4'h0, 16'h0030, 32'h0), mk(4'h0, 16'h0031, 32'h0));
    step(2'b01, 32'h3000_0004, 32'h3100_0005);
    step(2'b10, 32'h3000_0004, 32'h3100_0005);
    drain();

    // Reset mid-flight: two reads in flight are flushed; pointer back to 0.
    drive(2'b10, NOP, mk(4'h0, 16'h0050, 32'h0));
    step(2'b10, 32'h0, pat(16'h0050));
    drive(2'b01, mk(4'h0, 16'h0051, 32'h0), NOP);
    step(2'b01, pat(16'h0051), 32'h0);
    rst = 1'b1;
    drive(2'b11, mk(4'h0, 16'h0052, 32'h0), mk(4'h0, 16'h0053, 32'h0));
    step(2'b00, 32'h0, 32'h0);
    rst = 1'b0;
    step(2'b01, pat(16'h0052), pat(16'h0053));
    step(2'b10, pat(16'h0052), pat(16'h0053));
    drain();

    // Back-to-back random reads checked for data, latency and order.
    reset_cycle();
    ptr_m = 1'b0;
    for (int n = 0; n < 20; n++) begin
      v  = 2'($urandom_range(1, 3));
      a0 = 16'($urandom_range(16'h0060, 16'h00FF));
      a1 = 16'($urandom_range(16'h0060, 16'h00FF));
      drive(v, mk(4'h0, a0, 32'h0), mk(4'h0, a1, 32'h0));
      eg = (v == 2'b11) ? (ptr_m ? 2'b10 : 2'b01) : v;
      ptr_m = eg[0];
      step(eg, pat(a0), pat(a1));
    end
    drain();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
